ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage: owns the PC and issues word fetches on the instruction bus.
- Returns each fetched instruction with its address and a valid flag, through an output register, to the IF/ID pipeline register.
- Handles jump redirects from execute, discarding any in-flight stale fetch.
- Holds one completed instruction while the pipeline is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; the first fetch address.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- stall_i  input  `STALL_WIDTH  pipeline stall vector; this block uses bit `STALL_PC only.
- jump_flag_i  input  1  redirect request from execute, one-cycle pulse.
- jump_addr_i  input  32  redirect target; low 2 bits are ignored and treated as 0.
- ibus_req_o  output  1  fetch request.
- ibus_addr_o  output  32  fetch address; word aligned.
- ibus_gnt_i  input  1  bus accepts the request in this cycle.
- ibus_rvalid_i  input  1  response data valid.
- ibus_rdata_i  input  32  response instruction word.
- inst_o  output  32  fetched instruction, registered.
- inst_addr_o  output  32  address of inst_o, registered.
- inst_valid_o  output  1  inst_o/inst_addr_o hold a live instruction, registered.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE; pc=RESET_PC; req_addr=0; discard=0.
  - inst_o=0, inst_addr_o=0, inst_valid_o=0; ibus_req_o=0.
- stall = stall_i[`STALL_PC]. Every register update is clocked by clk.
- Outputs driven from state:
  - ibus_req_o=1 only in state REQ.
  - ibus_addr_o=pc in every state.
- At most one outstanding bus transaction at any time.
- FSM states IDLE, REQ, RSP, HOLD. Evaluate in this order each cycle:
  - IDLE: go to REQ unconditionally. The first request appears in cycle 1 after reset release.
  - REQ, gnt=1: req_addr<=pc; pc<=pc+4, mod 2^32 with silent wrap; go to RSP.
  - REQ, gnt=0: stay in REQ.
  - RSP, rvalid=1 and discard=1: drop the data; discard<=0; go to REQ.
  - RSP, rvalid=1 and discard=0:
    - inst_o<=rdata, inst_addr_o<=req_addr, inst_valid_o<=1.
    - Go to HOLD if stall=1, else go to REQ.
  - HOLD: keep the outputs unchanged while stall=1; go to REQ the first cycle stall=0.
- Consumption of the output register:
  - In any cycle with inst_valid_o=1, stall=0 and no new load, inst_valid_o<=0.
  - inst_o and inst_addr_o keep their last values.
- Jump, highest priority, applied in the same cycle as the rules above:
  - pc<={jump_addr_i[31:2],2'b00}; inst_valid_o<=0.
  - If the state is RSP, or it is REQ with gnt=1 in this cycle: discard<=1.
  - Exception: if rvalid=1 arrives in the jump cycle, that response is dropped and discard is not set.
  - If the state is HOLD, go to REQ.
  - The next request uses the new pc.
- A jump and rvalid in the same cycle: the response is dropped and no output load occurs.
- Stall never cancels an outstanding transaction. It only blocks leaving HOLD.
- Throughput: one instruction per 2 cycles with zero-wait grant and a 1-cycle response.
- Latency: inst_valid_o rises one cycle after the rvalid cycle.
- Reset mid-transaction: all state clears immediately. A response arriving after reset release while in IDLE/REQ is ignored, because rvalid is only sampled in RSP.

Test Plan:
- Reset with RESET_PC=32'h100, gnt and rvalid always one cycle after req -> addresses 0x100, 0x104, 0x108 on the bus; inst_valid_o pulses with inst_addr_o=0x100, 0x104, 0x108 in order.
- gnt held low for 3 cycles -> ibus_req_o stays 1 and ibus_addr_o stays 0x100; pc advances only on the grant cycle.
- Response for 0x104 arrives with stall=1 for 4 cycles -> inst_valid_o=1 and inst_o stable for all 4 cycles; no new request during the stall; request for 0x108 is issued the cycle after stall falls.
- jump_flag_i with jump_addr_i=0x2003 while in RSP for 0x10C -> 0x10C data never reaches the outputs; next request address is 0x2000; next valid output has inst_addr_o=0x2000.
- Jump and rvalid in the same cycle -> no valid output for that data; inst_valid_o=0 the next cycle; fetch resumes at the jump target.
- pc=0xFFFF_FFFC granted -> next request address is 0x0000_0000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC ownership, single-outstanding bus fetch, IF/ID output register.

`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [`STALL_WIDTH-1:0] stall_i,
  input  logic                    jump_flag_i,
  input  logic [31:0]             jump_addr_i,
  output logic                    ibus_req_o,
  output logic [31:0]             ibus_addr_o,
  input  logic                    ibus_gnt_i,
  input  logic                    ibus_rvalid_i,
  input  logic [31:0]             ibus_rdata_i,
  output logic [31:0]             inst_o,
  output logic [31:0]             inst_addr_o,
  output logic                    inst_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic        load;
  logic        stall;
  logic        in_unused;

  assign stall     = stall_i[`STALL_PC];
  assign in_unused = ^{stall_i, jump_addr_i[1:0]};

  assign ibus_req_o   = (state_q == REQ);
  assign ibus_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = valid_q;

  // Next-state, PC, discard tracking and output-register load/consume.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    discard_d   = discard_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    load        = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ibus_gnt_i) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = RSP;
        end
      end
      RSP: begin
        if (ibus_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else if (!jump_flag_i) begin
            load    = 1'b1;
            state_d = stall ? HOLD : REQ;
          end else begin
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      inst_d      = ibus_rdata_i;
      inst_addr_d = req_addr_q;
      valid_d     = 1'b1;
    end else if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    // Jump overrides the PC and output valid; a response landing in the jump cycle is simply dropped.
    if (jump_flag_i) begin
      pc_d    = {jump_addr_i[31:2], 2'b00};
      valid_d = 1'b0;
      if ((state_q == RSP && !ibus_rvalid_i) || (state_q == REQ && ibus_gnt_i))
        discard_d = 1'b1;
      if (state_q == HOLD)
        state_d = REQ;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      discard_q   <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      discard_q   <= discard_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a transaction-level model of the fetch stage.

`ifndef STALL_WIDTH
`define STALL_WIDTH 6
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif

module tb_ifu_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int unsigned NCYC = 4000;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [`STALL_WIDTH-1:0] stall_i;
  logic                    jump_flag_i;
  logic [31:0]             jump_addr_i;
  logic                    ibus_req_o;
  logic [31:0]             ibus_addr_o;
  logic                    ibus_gnt_i;
  logic                    ibus_rvalid_i;
  logic [31:0]             ibus_rdata_i;
  logic [31:0]             inst_o;
  logic [31:0]             inst_addr_o;
  logic                    inst_valid_o;

  ifu_fetch #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Model: transaction view -- booting, one outstanding fetch (possibly stale), held output.
  bit          m_boot, m_out, m_stale, m_hold, m_valid;
  logic [31:0] m_pc, m_out_addr, m_inst, m_iaddr;

  // Bus slave
  bit          s_pend;
  int unsigned s_cnt;
  logic [31:0] s_addr;

  // Per-cycle stimulus
  bit          stall_b, jump_b, gnt_b, rvalid_b;
  logic [31:0] jaddr_b;
  bit          req_seen;
  logic [31:0] addr_seen;

  task automatic model_reset();
    m_boot = 1; m_out = 0; m_stale = 0; m_hold = 0; m_valid = 0;
    m_pc = RPC; m_out_addr = '0; m_inst = '0; m_iaddr = '0;
    s_pend = 0; s_cnt = 0; s_addr = '0;
  endtask

  task automatic model_step();
    bit req_now, grant, resp, loaded;
    logic [31:0] tgt;
    req_now = !m_boot && !m_out && !m_hold;
    grant   = req_now && gnt_b;
    resp    = m_out && rvalid_b;
    loaded  = resp && !m_stale && !jump_b;
    tgt     = jaddr_b & 32'hFFFF_FFFC;

    if (loaded) begin
      m_inst = data_of(m_out_addr); m_iaddr = m_out_addr; m_valid = 1;
    end else if (m_valid && !stall_b) m_valid = 0;
    if (jump_b) m_valid = 0;

    if (loaded) m_hold = stall_b;
    else if (m_hold) m_hold = stall_b && !jump_b;

    if (grant) begin
      m_out = 1; m_out_addr = m_pc; m_stale = jump_b;
      m_pc = jump_b ? tgt : m_pc + 32'd4;
    end else begin
      if (resp) begin m_out = 0; m_stale = 0; end
      else if (jump_b && m_out) m_stale = 1;
      if (jump_b) m_pc = tgt;
    end
    m_boot = 0;
  endtask

  task automatic slave_step();
    if (s_pend) begin
      if (s_cnt == 0) s_pend = 0;
      else s_cnt--;
    end
    if (req_seen && gnt_b) begin
      s_pend = 1; s_addr = addr_seen; s_cnt = $urandom_range(0, 2);
    end
  endtask

  task automatic check_reset();
    check("rst_req",   {31'd0, ibus_req_o},   32'd0);
    check("rst_addr",  ibus_addr_o,           RPC);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_inst",  inst_o,                32'd0);
    check("rst_iaddr", inst_addr_o,           32'd0);
  endtask

  initial begin
    stall_i = '0; jump_flag_i = 0; jump_addr_i = '0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      check("req",   {31'd0, ibus_req_o},   {31'd0, !m_boot && !m_out && !m_hold});
      check("addr",  ibus_addr_o,           m_pc);
      check("valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
      check("inst",  inst_o,                m_inst);
      check("iaddr", inst_addr_o,           m_iaddr);

      if (cyc == NCYC / 2) begin
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end

      stall_b  = ($urandom_range(0, 99) < 30);
      jump_b   = ($urandom_range(0, 99) < 6);
      gnt_b    = ($urandom_range(0, 99) < 65);
      rvalid_b = s_pend && (s_cnt == 0);
      case ($urandom_range(0, 3))
        0: jaddr_b = 32'h0000_2003;
        1: jaddr_b = 32'hFFFF_FFFC;
        2: jaddr_b = $urandom;
        default: jaddr_b = 32'hFFFF_FFF9;
      endcase

      stall_i              = `STALL_WIDTH'($urandom);
      stall_i[`STALL_PC]   = stall_b;
      jump_flag_i          = jump_b;
      jump_addr_i          = jaddr_b;
      ibus_gnt_i           = gnt_b;
      ibus_rvalid_i        = rvalid_b;
      ibus_rdata_i         = rvalid_b ? data_of(s_addr) : $urandom;
      req_seen             = ibus_req_o;
      addr_seen            = ibus_addr_o;

      @(posedge clk);
      model_step();
      slave_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
